// File: rtl/led_strip_pkg.sv
// -----------------------------------------------------------------------------
// led_strip_pkg
// Shared constants for the WS2812-style LED strip driver:
//   - FSM state encoding (IDLE / LOAD / SEND / LATCH)
//   - colour order of the serial word (GRB) and bits per LED
//   - default timing constants for a 50 MHz system clock
//   - packWord helper that assembles the 24-bit word in the selected order
// No ports (package).
// -----------------------------------------------------------------------------
package led_strip_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    // Colour order of the word on the wire
    localparam logic [1:0] ORDER_GRB   = 2'd0;
    localparam logic [1:0] ORDER_RGB   = 2'd1;
    localparam logic [1:0] COLOR_ORDER = ORDER_GRB;

    localparam int BITS_PER_LED = 24;

    // Defaults for a 50 MHz clock
    localparam int DEF_MAX_POS   = 109;
    localparam int DEF_T0H_CYC   = 20;
    localparam int DEF_T1H_CYC   = 40;
    localparam int DEF_BIT_CYC   = 63;
    localparam int DEF_LATCH_CYC = 3000;
    localparam int DEF_DIM_SHIFT = 2;

    // Assemble the transmitted word, first bit on the wire in bit 23
    function automatic logic [23:0] packWord(input logic [1:0] order,
                                             input logic [7:0] g,
                                             input logic [7:0] r,
                                             input logic [7:0] b);
        logic [23:0] w;
        case (order)
            ORDER_RGB: w = {r, g, b};
            default:   w = {g, r, b};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// -----------------------------------------------------------------------------
// ws2812_bit_encoder
// Generates the waveform of one WS2812 bit period. A start pulse begins a new
// period on the following cycle; dout is high for T1H_CYC (bit=1) or T0H_CYC
// (bit=0) cycles and low for the remainder of the BIT_CYC-cycle period.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start_i    in   begin a new bit period next cycle (may coincide with bit_done_o)
//   bit_i      in   value of the bit being sent; must be held for the whole period
//   dout_o     out  registered serial output
//   bit_done_o out  high on the last cycle of a bit period
// -----------------------------------------------------------------------------
module ws2812_bit_encoder #(
    parameter int T0H_CYC = 20,
    parameter int T1H_CYC = 40,
    parameter int BIT_CYC = 63
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic bit_i,
    output logic dout_o,
    output logic bit_done_o
);

    localparam int CW = $clog2(BIT_CYC);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] T0H  = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H  = CW'(T1H_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic          dout_q, dout_d;

    // dout is computed for the cycle about to start, so the registered output
    // lines up exactly with the counter value it belongs to. A start always
    // opens with a high cycle since both high times are at least one cycle.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        dout_d   = 1'b0;
        if (start_i) begin
            cnt_d    = '0;
            active_d = 1'b1;
            dout_d   = 1'b1;
        end else if (active_q) begin
            if (cnt_q == LAST) begin
                cnt_d    = '0;
                active_d = 1'b0;
            end else begin
                cnt_d  = cnt_q + CW'(1);
                dout_d = (cnt_d < (bit_i ? T1H : T0H));
            end
        end
    end

    // Period counter and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            dout_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            dout_q   <= dout_d;
        end
    end

    assign dout_o     = dout_q;
    assign bit_done_o = active_q && (cnt_q == LAST);

endmodule

// File: rtl/led_strip_driver.sv
// -----------------------------------------------------------------------------
// led_strip_driver
// Scans LED indices 0..MAX_POS-1, samples the compositor's G/R/B intensities
// and serialises them MSB first (GRB order) as a WS2812-style stream, followed
// by a LATCH_CYC-cycle low gap. Frames repeat while enable is high; a frame in
// progress always completes.
// Optional feature: define LED_DIMMER_EN to capture each channel as
// (intensity >> DIM_SHIFT). Timing is identical in both builds.
// Ports:
//   clk                  in   system clock
//   rst_n                in   asynchronous active-low reset
//   enable               in   keep refreshing the strip while high
//   current_led          out  LED index presented to the compositor
//   led_green_intensity  in   green value for current_led
//   led_red_intensity    in   red value for current_led
//   led_blue_intensity   in   blue value for current_led
//   dout                 out  registered serial data to the strip
//   busy                 out  high whenever the FSM is not idle
//   frame_done           out  one-cycle pulse on the last latch cycle
// -----------------------------------------------------------------------------
module led_strip_driver
    import led_strip_pkg::*;
#(
    parameter int MAX_POS   = DEF_MAX_POS,
    parameter int T0H_CYC   = DEF_T0H_CYC,
    parameter int T1H_CYC   = DEF_T1H_CYC,
    parameter int BIT_CYC   = DEF_BIT_CYC,
    parameter int LATCH_CYC = DEF_LATCH_CYC,
    parameter int DIM_SHIFT = DEF_DIM_SHIFT,
    localparam int IW       = $clog2(MAX_POS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    output logic [IW-1:0] current_led,
    input  logic [7:0]    led_green_intensity,
    input  logic [7:0]    led_red_intensity,
    input  logic [7:0]    led_blue_intensity,
    output logic          dout,
    output logic          busy,
    output logic          frame_done
);

`ifdef LED_DIMMER_EN
    localparam bit DIM_ON = 1'b1;
`else
    localparam bit DIM_ON = 1'b0;
`endif
    localparam int SHIFT = DIM_ON ? DIM_SHIFT : 0;

    localparam int LW = $clog2(LATCH_CYC);
    localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYC - 1);
    localparam logic [IW-1:0] LED_LAST   = IW'(MAX_POS - 1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] led_q, led_d;
    logic [23:0]   shreg_q, shreg_d;
    logic [4:0]    bitCnt_q, bitCnt_d;
    logic [LW-1:0] latchCnt_q, latchCnt_d;
    logic [23:0]   word;
    logic          encStart;
    logic          bitDone;

    // Captured word; with the dimmer disabled SHIFT is zero and the
    // channels pass through untouched.
    assign word = packWord(COLOR_ORDER,
                           led_green_intensity >> SHIFT,
                           led_red_intensity   >> SHIFT,
                           led_blue_intensity  >> SHIFT);

    // Frame sequencer. The next bit period is started in the same cycle the
    // current one finishes, so bits within a word are back to back; only the
    // LOAD cycle separates consecutive words.
    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        shreg_d    = shreg_q;
        bitCnt_d   = bitCnt_q;
        latchCnt_d = latchCnt_q;
        encStart   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_LOAD;
                    led_d   = '0;
                end
            end
            ST_LOAD: begin
                shreg_d  = word;
                bitCnt_d = 5'(BITS_PER_LED - 1);
                encStart = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (bitDone) begin
                    shreg_d = {shreg_q[22:0], 1'b0};
                    if (bitCnt_q == 5'd0) begin
                        if (led_q == LED_LAST) begin
                            state_d    = ST_LATCH;
                            latchCnt_d = '0;
                        end else begin
                            led_d   = led_q + IW'(1);
                            state_d = ST_LOAD;
                        end
                    end else begin
                        bitCnt_d = bitCnt_q - 5'd1;
                        encStart = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (latchCnt_q == LATCH_LAST) begin
                    led_d   = '0;
                    state_d = enable ? ST_LOAD : ST_IDLE;
                end else begin
                    latchCnt_d = latchCnt_q + LW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            led_q      <= '0;
            shreg_q    <= '0;
            bitCnt_q   <= '0;
            latchCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            shreg_q    <= shreg_d;
            bitCnt_q   <= bitCnt_d;
            latchCnt_q <= latchCnt_d;
        end
    end

    // shreg_q[23] is the bit currently on the wire; it only shifts at the end
    // of a period, so it stays valid for the encoder the whole time.
    ws2812_bit_encoder #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_bit_encoder (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (encStart),
        .bit_i      (shreg_q[23]),
        .dout_o     (dout),
        .bit_done_o (bitDone)
    );

    assign current_led = led_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = (state_q == ST_LATCH) && (latchCnt_q == LATCH_LAST);

endmodule

// File: tb/tb_led_strip_driver.sv
// -----------------------------------------------------------------------------
// tb_led_strip_driver
// Directed bench for led_strip_driver with a 3-LED strip and short timings
// (T0H=2, T1H=4, BIT=6, LATCH=10). Decodes the serial stream by high time and
// compares it, plus frame length and control outputs, with hand-computed values.
// Define LED_DIMMER_EN for both bench and RTL to exercise the dimmer build.
// -----------------------------------------------------------------------------
module tb_led_strip_driver;

`ifdef LED_DIMMER_EN
    localparam int TB_SHIFT = 2;
    localparam logic [23:0] EXP_WORD_A = 24'h29003F;
    localparam logic [7:0]  EXP_FF     = 8'h3F;
`else
    localparam int TB_SHIFT = 0;
    localparam logic [23:0] EXP_WORD_A = 24'hA500FF;
    localparam logic [7:0]  EXP_FF     = 8'hFF;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] current_led;
    logic [7:0] gIn, rIn, bIn;
    logic       dout, busy, frame_done;

    logic       indexMode;
    logic [7:0] gConst, rConst, bConst;

    int  checkCount = 0;
    int  failCount  = 0;

    bit         bitQ[$];
    logic [1:0] ledLog[$];
    logic [1:0] prevLed;
    logic       prevDout;
    int  runLen, lowRun, lowAtFd, badRuns, fdCount, busyCycles, highCycles;
    bit  ok;

    // 10 ns clock
    always #5 clk = ~clk;

    // Compositor model: either constant colours or green = LED index, pre-scaled
    // so the dimmer build still decodes to the plain index.
    always_comb begin
        gIn = indexMode ? (8'(current_led) << TB_SHIFT) : gConst;
        rIn = rConst;
        bIn = bConst;
    end

    led_strip_driver #(
        .MAX_POS   (3),
        .T0H_CYC   (2),
        .T1H_CYC   (4),
        .BIT_CYC   (6),
        .LATCH_CYC (10),
        .DIM_SHIFT (2)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .current_led         (current_led),
        .led_green_intensity (gIn),
        .led_red_intensity   (rIn),
        .led_blue_intensity  (bIn),
        .dout                (dout),
        .busy                (busy),
        .frame_done          (frame_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] g, input logic [7:0] r,
                                 input logic [7:0] b, input logic idx);
        enable    = en;
        gConst    = g;
        rConst    = r;
        bConst    = b;
        indexMode = idx;
    endtask

    task automatic clearMon();
        bitQ.delete();
        ledLog.delete();
        ledLog.push_back(current_led);
        prevLed    = current_led;
        prevDout   = dout;
        runLen     = 0;
        lowRun     = 0;
        lowAtFd    = 0;
        badRuns    = 0;
        fdCount    = 0;
        busyCycles = 0;
        highCycles = 0;
    endtask

    // One clock, sampled on the falling edge; decodes high-time runs into bits.
    task automatic tick();
        @(negedge clk);
        if (dout) begin
            runLen++;
            highCycles++;
            lowRun = 0;
        end else begin
            if (prevDout) begin
                if (runLen == 4)      bitQ.push_back(1'b1);
                else if (runLen == 2) bitQ.push_back(1'b0);
                else                  badRuns++;
                runLen = 0;
            end
            lowRun++;
        end
        prevDout = dout;
        if (busy) busyCycles++;
        if (frame_done) begin
            fdCount++;
            lowAtFd = lowRun;
        end
        if (current_led != prevLed) begin
            ledLog.push_back(current_led);
            prevLed = current_led;
        end
    endtask

    task automatic waitFrameDone(input int maxCyc, output bit done);
        done = 1'b0;
        for (int i = 0; i < maxCyc; i++) begin
            tick();
            if (frame_done) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [7:0] getByte(input int led, input int chan);
        logic [7:0] v = 8'h00;
        int base = 24 * led + 8 * chan;
        for (int k = 0; k < 8; k++) begin
            if (base + k < bitQ.size()) v = {v[6:0], bitQ[base + k]};
            else                        v = {v[6:0], 1'b0};
        end
        return v;
    endfunction

    function automatic logic [23:0] getWord(input int led);
        return {getByte(led, 0), getByte(led, 1), getByte(led, 2)};
    endfunction

    initial begin
        // Reset and idle
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        checkOutput("reset_dout", 32'(dout), 32'd0);
        checkOutput("reset_led", 32'(current_led), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        clearMon();
        repeat (20) tick();
        checkOutput("idle_busy_cycles", 32'(busyCycles), 32'd0);
        checkOutput("idle_dout_high_cycles", 32'(highCycles), 32'd0);

        // Single frame of A5/00/FF
        clearMon();
        applyStimulus(1'b1, 8'hA5, 8'h00, 8'hFF, 1'b0);
        waitFrameDone(1000, ok);
        checkOutput("frame1_timeout", 32'(ok), 32'd1);
        enable = 1'b0;
        repeat (3) tick();
        checkOutput("frame1_bits", 32'(bitQ.size()), 32'd72);
        checkOutput("frame1_bad_runs", 32'(badRuns), 32'd0);
        for (int l = 0; l < 3; l++)
            checkOutput($sformatf("frame1_word%0d", l), 32'(getWord(l)), 32'(EXP_WORD_A));
        checkOutput("dim_blue_ff", 32'(getByte(0, 2)), 32'(EXP_FF));
        checkOutput("frame1_length", 32'(busyCycles), 32'd445);
        checkOutput("frame1_done_pulses", 32'(fdCount), 32'd1);
        checkOutput("frame1_idle_busy", 32'(busy), 32'd0);

        // Index sampling: green = LED index
        clearMon();
        applyStimulus(1'b1, 8'h00, 8'h3C, 8'h81, 1'b1);
        waitFrameDone(1000, ok);
        checkOutput("index_timeout", 32'(ok), 32'd1);
        enable = 1'b0;
        repeat (3) tick();
        for (int l = 0; l < 3; l++)
            checkOutput($sformatf("index_green%0d", l), 32'(getByte(l, 0)), l);
        checkOutput("index_red1", 32'(getByte(1, 1)), 32'(8'h3C >> TB_SHIFT));
        checkOutput("index_log_len", 32'(ledLog.size()), 32'd4);
        if (ledLog.size() == 4) begin
            checkOutput("index_log0", 32'(ledLog[0]), 32'd0);
            checkOutput("index_log1", 32'(ledLog[1]), 32'd1);
            checkOutput("index_log2", 32'(ledLog[2]), 32'd2);
            checkOutput("index_log3", 32'(ledLog[3]), 32'd0);
        end

        // enable drops during bit 5 of LED 1; frame must still complete
        clearMon();
        applyStimulus(1'b1, 8'hA5, 8'h00, 8'hFF, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (bitQ.size() == 29) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("drop_reach_timeout", 32'(ok), 32'd1);
        enable = 1'b0;
        waitFrameDone(1000, ok);
        checkOutput("drop_timeout", 32'(ok), 32'd1);
        repeat (4) tick();
        checkOutput("drop_bits", 32'(bitQ.size()), 32'd72);
        checkOutput("drop_word2", 32'(getWord(2)), 32'(EXP_WORD_A));
        checkOutput("drop_latch_low", 32'(lowAtFd), 32'd12);
        checkOutput("drop_length", 32'(busyCycles), 32'd445);
        checkOutput("drop_done_pulses", 32'(fdCount), 32'd1);
        checkOutput("drop_idle_busy", 32'(busy), 32'd0);

        // Reset asserted mid-SEND of LED 1 while dout is high
        clearMon();
        applyStimulus(1'b1, 8'h00, 8'h55, 8'hAA, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (bitQ.size() >= 30 && dout) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("midreset_reach_timeout", 32'(ok), 32'd1);
        checkOutput("midreset_pre_dout", 32'(dout), 32'd1);
        checkOutput("midreset_pre_led", 32'(current_led), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_dout", 32'(dout), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_led", 32'(current_led), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        clearMon();
        waitFrameDone(1000, ok);
        checkOutput("restart_timeout", 32'(ok), 32'd1);
        enable = 1'b0;
        repeat (3) tick();
        checkOutput("restart_bits", 32'(bitQ.size()), 32'd72);
        checkOutput("restart_green0", 32'(getByte(0, 0)), 32'd0);
        checkOutput("restart_green2", 32'(getByte(2, 0)), 32'd2);
        checkOutput("restart_length", 32'(busyCycles), 32'd445);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
